// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
// Optional build macro: ALU_ARBITER_FIXED_PRIO_EN (requester 0 always wins contention).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [2:0]       alu_op_code,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             grant;
  logic             owner_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is asking.
  always_comb begin
    grant = req0_valid ? 1'b0 : 1'b1;
  end
`else
  // last_q holds the requester granted most recently; reset to 1 so requester 0 wins first.
  logic last_q;

  // Round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = ~req0_valid;
  end

  // History pointer only moves when a command is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= grant;
  end
`endif

  // FSM next-state and handshake outputs; ready is masked while reset is held.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (!owner_q) begin
          rsp0_valid = 1'b1;
          rsp0_data  = result_q;
          if (rsp0_ready) state_nxt = IDLE;
        end else begin
          rsp1_valid = 1'b1;
          rsp1_data  = result_q;
          if (rsp1_ready) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command capture on acceptance; result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= grant ? req1_op : req0_op;
        a_q     <= grant ? req1_a  : req0_a;
        b_q     <= grant ? req1_b  : req0_b;
        owner_q <= grant;
      end
      if (state == EXEC) result_q <= alu_y;
    end
  end

  // The command registers only change on entry to EXEC, so they hold their value elsewhere.
  assign alu_op_code = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic [2:0]   alu_op_code;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         busy;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: pass-a, add, sub, and, or, inc-a, dec-a, pass-b.
  always_comb begin
    case (alu_op_code)
      3'd0:    alu_y = alu_a;
      3'd1:    alu_y = alu_a + alu_b;
      3'd2:    alu_y = alu_a - alu_b;
      3'd3:    alu_y = alu_a & alu_b;
      3'd4:    alu_y = alu_a | alu_b;
      3'd5:    alu_y = alu_a + 1;
      3'd6:    alu_y = alu_a - 1;
      default: alu_y = alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with both response readies high; own is the expected winner.
  task automatic run_txn(input string tag, input int own, input logic [W-1:0] exp);
    @(negedge clk);
    check({tag, "_rdy0"}, req0_ready, own == 0);
    check({tag, "_rdy1"}, req1_ready, own == 1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_exec_busy"}, busy, 1);
    check({tag, "_exec_rdy"}, {req0_ready, req1_ready}, 0);
    check({tag, "_exec_rspv"}, {rsp0_valid, rsp1_valid}, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rsp0v"}, rsp0_valid, own == 0);
    check({tag, "_rsp1v"}, rsp1_valid, own == 1);
    check({tag, "_rsp0d"}, rsp0_data, (own == 0) ? exp : '0);
    check({tag, "_rsp1d"}, rsp1_data, (own == 1) ? exp : '0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 32'h10;       sweep_exp[1] = 32'h30;
    sweep_exp[2] = 32'hFFFFFFF0; sweep_exp[3] = 32'h0;
    sweep_exp[4] = 32'h30;       sweep_exp[5] = 32'h11;
    sweep_exp[6] = 32'hF;        sweep_exp[7] = 32'h20;

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state, with a request held to prove ready is masked.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rspv", {rsp0_valid, rsp1_valid}, 0);
    check("rst_alu", {alu_op_code, alu_a[7:0], alu_b[7:0]}, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // Contention: both held valid, values chosen so each owner has a distinct result.
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd10;  req0_b = 32'd4;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'hF0;  req1_b = 32'h3C;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) run_txn($sformatf("fix%0d", i), 0, 32'd6);
`else
    for (int i = 0; i < 4; i++) run_txn($sformatf("rr%0d", i), i % 2, (i % 2) ? 32'h30 : 32'd6);
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single request: 5 + 3.
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd5; req0_b = 32'd3;
    run_txn("single", 0, 32'd8);

    // Op sweep on requester 0.
    req0_a = 32'h10; req0_b = 32'h20;
    for (int op = 0; op < 8; op++) begin
      req0_op = op[2:0];
      run_txn($sformatf("op%0d", op), 0, sweep_exp[op]);
    end
    req0_valid = 1'b0;

    // Backpressure on requester 1 while requester 0 keeps asking.
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'h0F; req1_b = 32'h30;
    rsp1_ready = 1'b0;
    @(negedge clk);
    check("bp_accept", req1_ready, 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_v%0d", i), rsp1_valid, 1);
      check($sformatf("bp_d%0d", i), rsp1_data, 32'h3F);
      check($sformatf("bp_rdy%0d", i), {req0_ready, req1_ready}, 0);
      check($sformatf("bp_busy%0d", i), busy, 1);
      @(posedge clk);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_done_busy", busy, 0);
    check("bp_done_v", rsp1_valid, 0);
    @(posedge clk);
    #1;

    // Reset while a response is pending.
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'h55; req0_b = 32'h0;
    rsp0_ready = 1'b0;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rspv", rsp0_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_v", rsp0_valid, 0);
    check("mid_rst_d", rsp0_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_v", rsp0_valid, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd100; req1_b = 32'd23;
    run_txn("post", 1, 32'd123);
    req1_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
